// File: rtl/cnn_act_pkg.sv
// Shared activation-stage definitions: element width, arbiter state encoding,
// round-robin selection and default datapath sizing used across conv/pool/act blocks.
package cnn_act_pkg;

    localparam int DEF_BITWIDTH        = 16;
    localparam int DEF_PARALLEL_FACTOR = 4;
    localparam int MAX_REQ             = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int elem_width(input int bitwidth);
        return 2 * bitwidth;
    endfunction

    // First set request at or after (ptr+1) mod num_req, wrapping; the
    // descending scan lets the nearest candidate overwrite farther ones.
    function automatic int rr_next(input logic [MAX_REQ-1:0] req,
                                   input int ptr,
                                   input int num_req);
        int pick;
        int idx;
        pick = 0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= num_req) begin
                idx = (ptr + i) % num_req;
                if (req[idx[2:0]]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/relu_lanes.sv
// Purely combinational ReLU across PARALLEL_FACTOR signed lanes: a negative
// lane (sign bit set) becomes zero, everything else passes through.
module relu_lanes
    import cnn_act_pkg::*;
#(
    parameter int PARALLEL_FACTOR = DEF_PARALLEL_FACTOR,
    parameter int EW              = elem_width(DEF_BITWIDTH)
) (
    input  logic [PARALLEL_FACTOR*EW-1:0] in_beat,
    output logic [PARALLEL_FACTOR*EW-1:0] out_beat
);

    for (genvar p = 0; p < PARALLEL_FACTOR; p++) begin : g_lane
        assign out_beat[p*EW +: EW] = in_beat[p*EW + EW - 1] ? '0 : in_beat[p*EW +: EW];
    end

endmodule

// File: rtl/relu_engine_arbiter.sv
// Round-robin, packet-locked arbiter sharing one registered ReLU engine among NUM_REQ
// producers. Optional stall-timeout abort is compiled in with `define ARB_TIMEOUT_EN.
module relu_engine_arbiter
    import cnn_act_pkg::*;
#(
    parameter int BITWIDTH        = DEF_BITWIDTH,
    parameter int PARALLEL_FACTOR = DEF_PARALLEL_FACTOR,
    parameter int NUM_REQ         = 3,
    parameter int ID_W            = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_REQ-1:0]                         in_valid,
    input  logic [NUM_REQ-1:0]                         in_last,
    input  logic [NUM_REQ*PARALLEL_FACTOR*(2*BITWIDTH)-1:0] in_data,
    output logic [NUM_REQ-1:0]                         in_ready,
    output logic                                       out_valid,
    output logic [PARALLEL_FACTOR*(2*BITWIDTH)-1:0]    out_data,
    output logic                                       out_last,
    output logic [ID_W-1:0]                            out_owner,
    input  logic                                       out_ready,
    output logic                                       busy,
    output logic                                       timeout_err
);

    localparam int EW     = elem_width(BITWIDTH);
    localparam int BEAT_W = PARALLEL_FACTOR * EW;

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || (1 << ID_W) < NUM_REQ || TIMEOUT_CYCLES < 1)
    begin : g_param_check
        $error("relu_engine_arbiter: illegal parameter combination");
    end

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [BEAT_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [ID_W-1:0]     out_owner_q, out_owner_d;

`ifdef ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    logic                owner_valid;
    logic                owner_last;
    logic [BEAT_W-1:0]   owner_data;
    logic [BEAT_W-1:0]   relu_data;
    logic                can_load;
    logic                accept;

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (owner_q == ID_W'(r)) begin
                owner_valid = in_valid[r];
                owner_last  = in_last[r];
                owner_data  = in_data[r*BEAT_W +: BEAT_W];
            end
        end
    end

    relu_lanes #(
        .PARALLEL_FACTOR (PARALLEL_FACTOR),
        .EW              (EW)
    ) u_relu_lanes (
        .in_beat  (owner_data),
        .out_beat (relu_data)
    );

    // Ready depends only on registered state and out_ready, never on in_valid.
    assign can_load = !out_valid_q || out_ready;
    assign accept   = (state_q == BUSY) && owner_valid && can_load;

    always_comb begin
        in_ready = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            in_ready[r] = (state_q == BUSY) && (owner_q == ID_W'(r)) && can_load;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_owner_d = out_owner_q;
`ifdef ARB_TIMEOUT_EN
        stall_d       = stall_q;
        timeout_err_d = 1'b0;
`endif
        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    owner_d = ID_W'(rr_next(MAX_REQ'(in_valid), int'(rr_ptr_q), NUM_REQ));
                    state_d = BUSY;
                    busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            BUSY: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = relu_data;
                    out_last_d  = owner_last;
                    out_owner_d = owner_q;
`ifdef ARB_TIMEOUT_EN
                    stall_d     = '0;
`endif
                    if (owner_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_q;
                        busy_d   = 1'b0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // Only an absent owner counts as a stall; downstream backpressure does not.
                else if (!owner_valid) begin
                    if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d       = IDLE;
                        rr_ptr_d      = owner_q;
                        busy_d        = 1'b0;
                        timeout_err_d = 1'b1;
                        stall_d       = '0;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_owner_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_owner_q   <= out_owner_d;
`ifdef ARB_TIMEOUT_EN
            stall_q       <= stall_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_owner = out_owner_q;
    assign busy      = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_relu_engine_arbiter.sv
// Directed bench for relu_engine_arbiter: reset, single stream, round-robin order,
// backpressure, mid-packet reset and stall timeout (or indefinite hold).
module tb_relu_engine_arbiter;

    localparam int NR  = 3;
    localparam int PF  = 4;
    localparam int EWB = 32;
    localparam int BW  = PF * EWB;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     in_valid;
    logic [NR-1:0]     in_last;
    logic [NR*BW-1:0]  in_data;
    logic [NR-1:0]     in_ready;
    logic              out_valid;
    logic [BW-1:0]     out_data;
    logic              out_last;
    logic [IDW-1:0]    out_owner;
    logic              out_ready;
    logic              busy;
    logic              timeout_err;

    always #5 clk = ~clk;

    relu_engine_arbiter #(
        .BITWIDTH        (16),
        .PARALLEL_FACTOR (PF),
        .NUM_REQ         (NR),
        .ID_W            (IDW),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_owner   (out_owner),
        .out_ready   (out_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Requester traffic engine state
    int             pkts_left[NR];
    int             beat_idx[NR];
    int             pkt_idx[NR];
    int             bpp;
    logic [NR-1:0]  acc_prev;
    int             cyc;
    logic [BW-1:0]  rec_data[$];
    logic [IDW-1:0] rec_owner[$];
    logic           rec_last[$];
    int             rec_cycle[$];

    function automatic logic [BW-1:0] mk(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] tag(input int r, input int p, input int b);
        return 32'h0000_A000 | 32'(r << 8) | 32'(p << 4) | 32'(b);
    endfunction

    // Lane0 positive tag, lane1 its complement (negative), lane2 max-positive, lane3 min-negative
    function automatic logic [BW-1:0] req_beat(input int r, input int p, input int b);
        return mk(tag(r, p, b), ~tag(r, p, b), 32'h7FFF_FFFF, 32'h8000_0000);
    endfunction

    function automatic logic [BW-1:0] exp_beat(input int r, input int p, input int b);
        return mk(tag(r, p, b), 32'h0, 32'h7FFF_FFFF, 32'h0);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int r = 0; r < NR; r++) begin
            pkts_left[r] = 0;
            beat_idx[r]  = 0;
            pkt_idx[r]   = 0;
        end
        acc_prev = '0;
        cyc      = 0;
        rec_data.delete();
        rec_owner.delete();
        rec_last.delete();
        rec_cycle.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic eng_cycle();
        for (int r = 0; r < NR; r++) begin
            if (acc_prev[r]) begin
                if (beat_idx[r] == bpp - 1) begin
                    beat_idx[r] = 0;
                    pkt_idx[r]++;
                    pkts_left[r]--;
                end else begin
                    beat_idx[r]++;
                end
            end
        end
        for (int r = 0; r < NR; r++) begin
            in_valid[r]            = (pkts_left[r] > 0);
            in_last[r]             = (beat_idx[r] == bpp - 1);
            in_data[r*BW +: BW]    = req_beat(r, pkt_idx[r], beat_idx[r]);
        end
        #1;
        acc_prev = in_valid & in_ready;
        if (out_valid && out_ready) begin
            rec_data.push_back(out_data);
            rec_owner.push_back(out_owner);
            rec_last.push_back(out_last);
            rec_cycle.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (in_ready !== 3'b000) $display("FAIL reset_in_ready got=%b exp=000", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else n_pass++;
        n_total++; if ({out_last, out_owner, busy, timeout_err} !== 5'b0)
            $display("FAIL reset_misc got=%b exp=00000", {out_last, out_owner, busy, timeout_err}); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_stream();
        logic [BW-1:0] e1, e2, e3;
        e1 = mk(32'h0000_0005, 32'h0, 32'h0, 32'h1234_5678);
        e2 = mk(32'h0, 32'h7FFF_FFFF, 32'h0, 32'h0000_0001);
        e3 = mk(32'h7FFF_FFFF, 32'h0, 32'h0000_0000, 32'h0);
        in_valid = 3'b010;
        in_last  = 3'b000;
        in_data[1*BW +: BW] = mk(32'h0000_0005, 32'h0, 32'h8000_0000, 32'h1234_5678);
        #1;
        n_total++; if (in_ready !== 3'b000) $display("FAIL single_idle_ready got=%b exp=000", in_ready); else n_pass++;
        tick();
        n_total++; if ({busy, in_ready, out_valid} !== 5'b1_010_0)
            $display("FAIL single_grant got=%b exp=10100", {busy, in_ready, out_valid}); else n_pass++;
        tick();
        n_total++; if ({out_valid, out_owner, out_last} !== 4'b1_01_0)
            $display("FAIL single_b1_ctl got=%b exp=1010", {out_valid, out_owner, out_last}); else n_pass++;
        n_total++; if (out_data !== e1) $display("FAIL single_b1_data got=%h exp=%h", out_data, e1); else n_pass++;
        in_data[1*BW +: BW] = mk(32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        n_total++; if (out_data !== e2) $display("FAIL single_b2_data got=%h exp=%h", out_data, e2); else n_pass++;
        in_data[1*BW +: BW] = mk(32'h7FFF_FFFF, 32'h8000_0001, 32'h0000_0000, 32'h8000_0000);
        in_last = 3'b010;
        tick();
        n_total++; if (out_data !== e3) $display("FAIL single_b3_data got=%h exp=%h", out_data, e3); else n_pass++;
        n_total++; if ({out_valid, out_last, out_owner, busy} !== 5'b1_1_01_0)
            $display("FAIL single_b3_ctl got=%b exp=11010", {out_valid, out_last, out_owner, busy}); else n_pass++;
        in_valid = '0;
        in_last  = '0;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        int multi;
        int n;
        reset_dut();
        bpp = 2;
        for (int r = 0; r < NR; r++) pkts_left[r] = 2;
        multi = 0;
        for (int c = 0; c < 60 && rec_data.size() < 12; c++) begin
            #1;
            if ($countones(in_ready) > 1) multi++;
            eng_cycle();
        end
        n_total++; if (rec_data.size() != 12) $display("FAIL rr_beat_count got=%0d exp=12", rec_data.size()); else n_pass++;
        n_total++; if (multi != 0) $display("FAIL rr_ready_onehot got=%0d exp=0", multi); else n_pass++;
        n = (rec_data.size() < 12) ? rec_data.size() : 12;
        for (int k = 0; k < n; k++) begin
            int pn, r, p, b;
            pn = k / 2; r = pn % 3; p = pn / 3; b = k % 2;
            n_total++; if (rec_owner[k] !== IDW'(r))
                $display("FAIL rr_owner[%0d] got=%0d exp=%0d", k, rec_owner[k], r); else n_pass++;
            n_total++; if (rec_data[k] !== exp_beat(r, p, b))
                $display("FAIL rr_data[%0d] got=%h exp=%h", k, rec_data[k], exp_beat(r, p, b)); else n_pass++;
            n_total++; if (rec_last[k] !== (b == 1))
                $display("FAIL rr_last[%0d] got=%b exp=%b", k, rec_last[k], (b == 1)); else n_pass++;
            n_total++; if (rec_cycle[k] != 2 + 3 * pn + b)
                $display("FAIL rr_cycle[%0d] got=%0d exp=%0d", k, rec_cycle[k], 2 + 3 * pn + b); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        reset_dut();
        bpp = 8;
        pkts_left[0] = 1;
        for (int c = 0; c < 40 && rec_data.size() < 8; c++) begin
            out_ready = !(c >= 4 && c < 9);
            #1;
            if (c >= 4 && c < 9) begin
                n_total++; if (in_ready !== 3'b000)
                    $display("FAIL bp_hold_ready c=%0d got=%b exp=000", c, in_ready); else n_pass++;
                n_total++; if (out_data !== exp_beat(0, 0, 2))
                    $display("FAIL bp_hold_data c=%0d got=%h exp=%h", c, out_data, exp_beat(0, 0, 2)); else n_pass++;
            end
            eng_cycle();
        end
        out_ready = 1'b1;
        n_total++; if (rec_data.size() != 8) $display("FAIL bp_count got=%0d exp=8", rec_data.size()); else n_pass++;
        n = (rec_data.size() < 8) ? rec_data.size() : 8;
        for (int k = 0; k < n; k++) begin
            n_total++; if (rec_data[k] !== exp_beat(0, 0, k))
                $display("FAIL bp_data[%0d] got=%h exp=%h", k, rec_data[k], exp_beat(0, 0, k)); else n_pass++;
            n_total++; if (rec_last[k] !== (k == 7))
                $display("FAIL bp_last[%0d] got=%b exp=%b", k, rec_last[k], (k == 7)); else n_pass++;
        end
        if (n == 8) begin
            n_total++; if (rec_cycle[2] != 9) $display("FAIL bp_release_cycle got=%0d exp=9", rec_cycle[2]); else n_pass++;
            n_total++; if (rec_cycle[7] != 14) $display("FAIL bp_final_cycle got=%0d exp=14", rec_cycle[7]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_packet();
        reset_dut();
        in_valid = 3'b100;
        in_last  = 3'b000;
        in_data[2*BW +: BW] = req_beat(2, 0, 0);
        tick();
        n_total++; if (in_ready !== 3'b100) $display("FAIL mrst_grant got=%b exp=100", in_ready); else n_pass++;
        tick();
        in_data[2*BW +: BW] = req_beat(2, 0, 1);
        n_total++; if ({out_valid, out_owner} !== 3'b1_10)
            $display("FAIL mrst_beat1 got=%b exp=110", {out_valid, out_owner}); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if ({out_valid, out_last, out_owner, busy, timeout_err} !== 6'b0)
            $display("FAIL mrst_ctl got=%b exp=000000", {out_valid, out_last, out_owner, busy, timeout_err}); else n_pass++;
        n_total++; if (out_data !== '0) $display("FAIL mrst_data got=%h exp=0", out_data); else n_pass++;
        n_total++; if (in_ready !== 3'b000) $display("FAIL mrst_ready got=%b exp=000", in_ready); else n_pass++;
        in_valid = 3'b101;
        in_data[0*BW +: BW] = req_beat(0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        n_total++; if ({busy, in_ready} !== 4'b1_001)
            $display("FAIL mrst_regrant got=%b exp=1001", {busy, in_ready}); else n_pass++;
        in_valid = '0;
        tick();
    endtask

    task automatic test_timeout();
        reset_dut();
        in_valid = 3'b011;
        in_last  = 3'b000;
        in_data[0*BW +: BW] = req_beat(0, 0, 0);
        in_data[1*BW +: BW] = req_beat(1, 0, 0);
        tick();
        n_total++; if (in_ready !== 3'b001) $display("FAIL to_grant0 got=%b exp=001", in_ready); else n_pass++;
        tick();
        in_valid[0] = 1'b0;
        n_total++; if ({out_valid, out_owner} !== 3'b1_00)
            $display("FAIL to_beat1 got=%b exp=100", {out_valid, out_owner}); else n_pass++;
`ifdef ARB_TIMEOUT_EN
        begin
            int early;
            early = 0;
            for (int i = 1; i <= 7; i++) begin
                tick();
                if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
            end
            n_total++; if (early != 0) $display("FAIL to_early got=%0d exp=0", early); else n_pass++;
            tick();
            n_total++; if ({timeout_err, busy} !== 2'b10)
                $display("FAIL to_pulse got=%b exp=10", {timeout_err, busy}); else n_pass++;
            tick();
            n_total++; if ({timeout_err, busy, in_ready} !== 5'b0_1_010)
                $display("FAIL to_next_grant got=%b exp=01010", {timeout_err, busy, in_ready}); else n_pass++;
        end
`else
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 120; i++) begin
                tick();
                if (timeout_err !== 1'b0 || busy !== 1'b1 || in_ready !== 3'b001) bad++;
            end
            n_total++; if (bad != 0) $display("FAIL hold_grant got=%0d bad cycles exp=0", bad); else n_pass++;
            in_valid[0] = 1'b1;
            in_last[0]  = 1'b1;
            in_data[0*BW +: BW] = req_beat(0, 0, 1);
            tick();
            n_total++; if ({out_valid, out_last, busy} !== 3'b110)
                $display("FAIL hold_resume got=%b exp=110", {out_valid, out_last, busy}); else n_pass++;
            n_total++; if (out_data !== exp_beat(0, 0, 1))
                $display("FAIL hold_resume_data got=%h exp=%h", out_data, exp_beat(0, 0, 1)); else n_pass++;
        end
`endif
        in_valid = '0;
        in_last  = '0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_backpressure();
        test_reset_mid_packet();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
